// File: rtl/rom_read_adapter.sv
// rtl/rom_read_adapter.sv - request/response adapter turning 32/64-bit byte-addressed reads into registered-ROM word reads
module rom_read_adapter #(
    parameter int ROM_WORDS = 2048
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [12:0] req_addr,
    input  logic        req_wide,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_err,
    output logic        rom_me,
    output logic        rom_oe,
    output logic [10:0] rom_address,
    input  logic [31:0] rom_q
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        RESP = 3'd4
    } state_t;

    // Last legal word index plus one, held in 12 bits so W+1 never wraps.
    localparam logic [11:0] LIMIT = 12'(ROM_WORDS);

    state_t      state_q, state_d;
    logic [10:0] word_q, word_d;
    logic        wide_q, wide_d;
    logic        err_q, err_d;
    logic [63:0] data_q, data_d;

    logic        hs;
    logic [11:0] end_idx;
    logic        req_err;

    assign hs      = req_valid & req_ready;
    assign end_idx = {1'b0, req_addr[12:2]} + {11'd0, req_wide};
    assign req_err = (req_addr[1:0] != 2'b00)
                   | (req_wide & req_addr[2])
                   | (end_idx >= LIMIT);

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (hs) state_d = req_err ? RESP : RD0;
            RD0:  state_d = RD1;
            RD1:  state_d = wide_q ? RD2 : RESP;
            RD2:  state_d = RESP;
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ROM strobes and handshake outputs decoded from the current state.
    always_comb begin
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        rom_me      = 1'b0;
        rom_oe      = 1'b0;
        rom_address = word_q;
        case (state_q)
            IDLE: req_ready = 1'b1;
            RD0:  rom_me = 1'b1;
            RD1: begin
                rom_oe = 1'b1;
                if (wide_q) begin
                    rom_me      = 1'b1;
                    rom_address = word_q + 11'd1;
                end
            end
            RD2:  rom_oe = 1'b1;
            RESP: resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: latch request at handshake, collect ROM words as they appear.
    always_comb begin
        word_d = word_q;
        wide_d = wide_q;
        err_d  = err_q;
        data_d = data_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    word_d = req_addr[12:2];
                    wide_d = req_wide;
                    err_d  = req_err;
                    data_d = '0;
                end
            end
            RD1: begin
                data_d[31:0] = rom_q;
                if (!wide_q) data_d[63:32] = '0;
            end
            RD2:  data_d[63:32] = rom_q;
            default: ;
        endcase
    end

    // Datapath registers; held steady through RESP so backpressure sees stable data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            wide_q <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
        end else begin
            word_q <= word_d;
            wide_q <= wide_d;
            err_q  <= err_d;
            data_q <= data_d;
        end
    end

    assign resp_data = data_q;
    assign resp_err  = err_q;

endmodule

// File: tb/tb_rom_read_adapter.sv
// tb/tb_rom_read_adapter.sv - scoreboard bench for rom_read_adapter with registered ROM models
module tb_rom_read_adapter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Main instance, ROM_WORDS = 2048
    logic        req_valid = 1'b0, req_ready, req_wide = 1'b0;
    logic [12:0] req_addr = '0;
    logic        resp_valid, resp_ready = 1'b1, resp_err;
    logic [63:0] resp_data;
    logic        rom_me, rom_oe;
    logic [10:0] rom_address;
    logic [31:0] rom_q;

    // Small instance, ROM_WORDS = 16
    logic        s_req_valid = 1'b0, s_req_ready, s_req_wide = 1'b0;
    logic [12:0] s_req_addr = '0;
    logic        s_resp_valid, s_resp_err;
    logic [63:0] s_resp_data;
    logic        s_rom_me, s_rom_oe;
    logic [10:0] s_rom_address;
    logic [31:0] s_rom_q;

    rom_read_adapter dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wide(req_wide),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
        .rom_me(rom_me), .rom_oe(rom_oe), .rom_address(rom_address), .rom_q(rom_q)
    );

    rom_read_adapter #(.ROM_WORDS(16)) dut16 (
        .clock(clock), .reset(reset),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_addr(s_req_addr), .req_wide(s_req_wide),
        .resp_valid(s_resp_valid), .resp_ready(1'b1), .resp_data(s_resp_data), .resp_err(s_resp_err),
        .rom_me(s_rom_me), .rom_oe(s_rom_oe), .rom_address(s_rom_address), .rom_q(s_rom_q)
    );

    // Registered ROM models: word appears one edge after rom_me, only while rom_oe.
    logic [31:0] rom_mem [0:2047];
    logic [31:0] rom_reg = '0;
    logic [31:0] s_rom_reg = '0;
    always @(posedge clock) if (rom_me) rom_reg <= rom_mem[rom_address];
    always @(posedge clock) if (s_rom_me) s_rom_reg <= 32'h5A00_0000 | {21'd0, s_rom_address};
    assign rom_q   = rom_oe   ? rom_reg   : 32'hBAAD_F00D;
    assign s_rom_q = s_rom_oe ? s_rom_reg : 32'hBAAD_F00D;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    // Issue one read on the main instance; expectation comes from the ROM contents and the address rules.
    task automatic do_read(input logic [12:0] addr, input logic wide, input int hold);
        exp_t e;
        int   w, lat, me_cnt, exp_lat, exp_me;
        logic [63:0] d0;
        w     = int'(addr[12:2]);
        e.err = (addr[1:0] != 2'b00) || (wide && addr[2]) || (w + int'(wide) >= 2048);
        if (e.err)     e.data = 64'd0;
        else if (wide) e.data = {rom_mem[w + 1], rom_mem[w]};
        else           e.data = {32'd0, rom_mem[w]};
        exp_lat = e.err ? 1 : (wide ? 4 : 3);
        exp_me  = e.err ? 0 : (wide ? 2 : 1);

        @(negedge clock);
        chk("req_ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_wide   = wide;
        resp_ready = (hold == 0);
        sb.push_back(e);
        @(posedge clock);
        #1 req_valid = 1'b0;

        lat = 0;
        me_cnt = 0;
        forever begin
            @(negedge clock);
            lat++;
            if (rom_me) begin
                chk("rom_me_addr", rom_address, 64'(w + me_cnt));
                me_cnt++;
            end
            if (resp_valid || lat >= 20) break;
        end
        chk("latency", lat, exp_lat);
        chk("rom_me_pulses", me_cnt, exp_me);
        if (!resp_valid) begin
            void'(sb.pop_front());
            resp_ready = 1'b1;
            return;
        end

        d0 = resp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("bp_data_stable", resp_data, d0);
            chk("bp_valid_held", resp_valid, 1);
            chk("bp_req_ready_low", req_ready, 0);
        end
        resp_ready = 1'b1;
        e = sb.pop_front();
        chk("resp_data", resp_data, e.data);
        chk("resp_err", resp_err, e.err);
        @(posedge clock);
        @(negedge clock);
        chk("ready_after_resp", req_ready, 1);
        chk("valid_after_resp", resp_valid, 0);
    endtask

    // Read on the 16-word instance.
    task automatic s_read(input logic [12:0] addr, input logic wide, input logic exp_err,
                          input logic [63:0] exp_data, input int exp_lat);
        int lat, me_cnt;
        @(negedge clock);
        s_req_valid = 1'b1;
        s_req_addr  = addr;
        s_req_wide  = wide;
        @(posedge clock);
        #1 s_req_valid = 1'b0;
        lat = 0;
        me_cnt = 0;
        forever begin
            @(negedge clock);
            lat++;
            if (s_rom_me) me_cnt++;
            if (s_resp_valid || lat >= 20) break;
        end
        chk("s_latency", lat, exp_lat);
        chk("s_resp_err", s_resp_err, exp_err);
        chk("s_resp_data", s_resp_data, exp_data);
        chk("s_rom_me_pulses", me_cnt, exp_err ? 0 : (wide ? 2 : 1));
        @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        for (int i = 0; i < 2048; i++) rom_mem[i] = 32'(i) * 32'h9E37_79B1 ^ 32'hC001_D00D;
        rom_mem[0]    = 32'hCAFE_0000;
        rom_mem[5]    = 32'hDEAD_BEEF;
        rom_mem[6]    = 32'h1111_1111;
        rom_mem[7]    = 32'h2222_2222;
        rom_mem[2046] = 32'h7E57_2046;
        rom_mem[2047] = 32'h7E57_2047;

        #12;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_rom_me", rom_me, 0);
        chk("rst_rom_oe", rom_oe, 0);
        chk("rst_rom_address", rom_address, 0);
        @(negedge clock);
        reset = 1'b0;

        do_read(13'h014, 1'b0, 0);
        do_read(13'h018, 1'b1, 0);
        do_read(13'h015, 1'b0, 0);
        do_read(13'h01C, 1'b1, 0);
        do_read(13'h014, 1'b0, 10);
        do_read(13'h018, 1'b1, 3);
        do_read(13'h1FFC, 1'b0, 0);
        do_read(13'h1FF8, 1'b1, 0);
        do_read(13'h1FFC, 1'b1, 0);

        s_read(13'h03C, 1'b1, 1'b1, 64'd0, 1);
        s_read(13'h040, 1'b0, 1'b1, 64'd0, 1);
        s_read(13'h03C, 1'b0, 1'b0, 64'h0000_0000_5A00_000F, 3);
        s_read(13'h038, 1'b1, 1'b0, 64'h5A00_000F_5A00_000E, 4);

        // Reset while the first beat of a wide read is being captured.
        @(negedge clock);
        req_valid = 1'b1;
        req_addr  = 13'h018;
        req_wide  = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("midrst_in_rd1_oe", rom_oe, 1);
        reset = 1'b1;
        #1;
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_resp_err", resp_err, 0);
        chk("midrst_resp_data", resp_data, 0);
        chk("midrst_rom_me", rom_me, 0);
        chk("midrst_rom_oe", rom_oe, 0);
        chk("midrst_rom_address", rom_address, 0);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (resp_valid) seen = 1'b1;
        end
        chk("midrst_no_resp", seen, 0);
        do_read(13'h000, 1'b0, 0);

        for (int k = 0; k < 24; k++) begin
            logic [12:0] a;
            a = 13'($urandom_range(0, 8191));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_read(a, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
